// File: rtl/stack_sequencer.sv
// stack_sequencer: runs PUSH/POP/DUP and binary ALU commands against an external stack.
module stack_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_wdata,
  input  logic [WIDTH-1:0] stk_rdata,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             err,
  output logic [2:0]       depth
);

  localparam logic [2:0] OP_PUSH   = 3'b000;
  localparam logic [2:0] OP_POP    = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_DUP    = 3'b111;
  localparam logic [2:0] DEPTH_MAX = 3'(DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PUSH = 3'd1,
    POP1 = 3'd2,
    POP2 = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             accept;
  logic             ok;

  // Binary result r = f(b, a), b being the deeper operand.
  function automatic logic [WIDTH-1:0] alu(input logic [2:0] op,
                                           input logic [WIDTH-1:0] b_in,
                                           input logic [WIDTH-1:0] a_in);
    case (op)
      OP_ADD:  alu = b_in + a_in;
      OP_SUB:  alu = b_in - a_in;
      OP_AND:  alu = b_in & a_in;
      OP_OR:   alu = b_in | a_in;
      default: alu = b_in ^ a_in;
    endcase
  endfunction

  assign accept = cmd_valid && (state == IDLE) && !rst;

  // Occupancy precondition for the offered command.
  always_comb begin
    ok = 1'b0;
    case (cmd_op)
      OP_PUSH: ok = depth < DEPTH_MAX;
      OP_POP:  ok = depth != 3'd0;
      OP_DUP:  ok = (depth != 3'd0) && (depth < DEPTH_MAX);
      default: ok = depth >= 3'd2;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and state-decoded handshake/stack controls.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !rst;
        if (accept && ok)
          next_state = ((cmd_op == OP_PUSH) || (cmd_op == OP_DUP)) ? PUSH : POP1;
      end
      PUSH: begin
        stk_push   = 1'b1;
        next_state = DONE;
      end
      POP1: begin
        stk_pop    = 1'b1;
        next_state = (op_q == OP_POP) ? DONE : POP2;
      end
      POP2: begin
        stk_pop    = 1'b1;
        next_state = PUSH;
      end
      DONE: begin
        res_valid  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand latches, write data, result, reject pulse and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      data_q    <= '0;
      a         <= '0;
      b         <= '0;
      stk_wdata <= '0;
      res_data  <= '0;
      err       <= 1'b0;
      depth     <= '0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        a      <= stk_rdata;
        if (!ok)                  err       <= 1'b1;
        else if (cmd_op == OP_PUSH) stk_wdata <= cmd_data;
        else if (cmd_op == OP_DUP)  stk_wdata <= stk_rdata;
      end
      case (state)
        PUSH: begin
          depth <= depth + 3'd1;
          if (op_q == OP_PUSH)     res_data <= data_q;
          else if (op_q == OP_DUP) res_data <= a;
          else                     res_data <= alu(op_q, b, a);
        end
        POP1: begin
          depth <= depth - 3'd1;
          if (op_q == OP_POP) res_data <= a;
        end
        POP2: begin
          depth     <= depth - 3'd1;
          b         <= stk_rdata;
          stk_wdata <= alu(op_q, stk_rdata, a);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: vector table plus scoreboard checking of stack_sequencer against a behavioural stack.
module tb_stack_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_DUP  = 3'b111;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'b000;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             stk_push;
  logic             stk_pop;
  logic [WIDTH-1:0] stk_wdata;
  logic [WIDTH-1:0] stk_rdata;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             err;
  logic [2:0]       depth;

  typedef struct {
    logic       is_err;
    logic [7:0] res;
    logic [2:0] dep;
    logic [7:0] wdata;
    int         due;
    int         npush;
    int         npop;
  } item_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic       is_err;
    logic [7:0] res;
    logic [2:0] dep;
  } vec_t;

  item_t sb[$];
  vec_t  vecs[$];
  item_t it;
  int    checks = 0;
  int    fails = 0;
  int    cyc = 0;
  int    accepts = 0;
  int    npush_seen = 0;
  int    npop_seen = 0;

  logic [7:0] mem [0:7];
  logic [3:0] sp;

  stack_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
    .res_valid(res_valid), .res_data(res_data), .err(err), .depth(depth)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (cmd_valid && cmd_ready) accepts <= accepts + 1;

  // Behavioural downstream stack, reset together with the sequencer.
  always @(posedge clk or posedge rst) begin
    if (rst) sp <= 4'd0;
    else if (stk_push && sp < 4'd8) begin
      mem[sp[2:0]] <= stk_wdata;
      sp <= sp + 4'd1;
    end else if (stk_pop && sp != 4'd0) sp <= sp - 4'd1;
  end
  assign stk_rdata = (sp != 4'd0) ? mem[3'(sp - 4'd1)] : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic item_t mk(input vec_t v, input int k);
    item_t r;
    r.is_err = v.is_err;
    r.res    = v.res;
    r.dep    = v.dep;
    r.wdata  = (v.op == OP_PUSH) ? v.data : v.res;
    if (v.is_err) begin
      r.due = k + 1; r.npush = 0; r.npop = 0;
    end else if (v.op == OP_PUSH || v.op == OP_DUP) begin
      r.due = k + 2; r.npush = 1; r.npop = 0;
    end else if (v.op == OP_POP) begin
      r.due = k + 2; r.npush = 0; r.npop = 1;
    end else begin
      r.due = k + 4; r.npush = 1; r.npop = 2;
    end
    return r;
  endfunction

  task automatic add(input logic [2:0] op, input logic [7:0] d, input logic e,
                     input logic [7:0] r, input logic [2:0] dp);
    vec_t v;
    v.op = op; v.data = d; v.is_err = e; v.res = r; v.dep = dp;
    vecs.push_back(v);
  endtask

  task automatic drain();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) return;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic wait_ready(output bit got);
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1'b1; break; end
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input vec_t v);
    bit got;
    wait_ready(got);
    if (!got) return;
    cmd_valid = 1'b1; cmd_op = v.op; cmd_data = v.data;
    sb.push_back(mk(v, cyc));
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_data = 8'($urandom);
    drain();
  endtask

  // Scoreboard monitor: compares each completion or reject pulse with the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      npush_seen = 0; npop_seen = 0;
    end else begin
      if (stk_push && stk_pop) check("push_pop_excl", 32'd1, 32'd0);
      if (stk_push) begin
        npush_seen++;
        if (sb.size() > 0 && !sb[0].is_err) check("stk_wdata", 32'(stk_wdata), 32'(sb[0].wdata));
      end
      if (stk_pop) npop_seen++;
      if (res_valid || err) begin
        if (sb.size() == 0) check("unexpected_pulse", 32'({res_valid, err}), 32'd0);
        else begin
          it = sb.pop_front();
          check("err_pulse", 32'(err), 32'(it.is_err));
          check("res_valid", 32'(res_valid), 32'(!it.is_err));
          check("latency", 32'(cyc), 32'(it.due));
          check("depth", 32'(depth), 32'(it.dep));
          if (!it.is_err) check("res_data", 32'(res_data), 32'(it.res));
          check("n_push", 32'(npush_seen), 32'(it.npush));
          check("n_pop", 32'(npop_seen), 32'(it.npop));
        end
        npush_seen = 0; npop_seen = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t hv;
    bit   got;
    int   acc0;
    int   k;

    add(OP_PUSH, 8'h01, 1'b0, 8'h01, 3'd1);
    add(OP_PUSH, 8'h02, 1'b0, 8'h02, 3'd2);
    add(OP_PUSH, 8'h03, 1'b0, 8'h03, 3'd3);
    add(OP_PUSH, 8'h04, 1'b0, 8'h04, 3'd4);
    add(OP_PUSH, 8'h05, 1'b1, 8'h00, 3'd4);
    add(OP_DUP,  8'h00, 1'b1, 8'h00, 3'd4);
    add(OP_POP,  8'h00, 1'b0, 8'h04, 3'd3);
    add(OP_POP,  8'h00, 1'b0, 8'h03, 3'd2);
    add(OP_POP,  8'h00, 1'b0, 8'h02, 3'd1);
    add(OP_POP,  8'h00, 1'b0, 8'h01, 3'd0);
    add(OP_POP,  8'h00, 1'b1, 8'h00, 3'd0);
    add(OP_PUSH, 8'h0A, 1'b0, 8'h0A, 3'd1);
    add(OP_XOR,  8'h00, 1'b1, 8'h00, 3'd1);
    add(OP_PUSH, 8'h03, 1'b0, 8'h03, 3'd2);
    add(OP_SUB,  8'h00, 1'b0, 8'h07, 3'd1);
    add(OP_DUP,  8'h00, 1'b0, 8'h07, 3'd2);
    add(OP_AND,  8'h00, 1'b0, 8'h07, 3'd1);
    add(OP_PUSH, 8'hFF, 1'b0, 8'hFF, 3'd2);
    add(OP_POP,  8'h00, 1'b0, 8'hFF, 3'd1);
    add(OP_POP,  8'h00, 1'b0, 8'h07, 3'd0);
    add(OP_PUSH, 8'hFF, 1'b0, 8'hFF, 3'd1);
    add(OP_PUSH, 8'h01, 1'b0, 8'h01, 3'd2);
    add(OP_ADD,  8'h00, 1'b0, 8'h00, 3'd1);
    add(OP_PUSH, 8'h01, 1'b0, 8'h01, 3'd2);
    add(OP_SUB,  8'h00, 1'b0, 8'hFF, 3'd1);
    add(OP_PUSH, 8'h0F, 1'b0, 8'h0F, 3'd2);
    add(OP_OR,   8'h00, 1'b0, 8'hFF, 3'd1);
    add(OP_PUSH, 8'h5A, 1'b0, 8'h5A, 3'd2);
    add(OP_XOR,  8'h00, 1'b0, 8'hA5, 3'd1);

    // Reset state, then release.
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({cmd_ready, stk_push, stk_pop, res_valid, err, depth, res_data, stk_wdata}), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(cmd_ready), 32'd1);
    check("depth_after_reset", 32'(depth), 32'd0);

    foreach (vecs[i]) issue(vecs[i]);

    // cmd_valid held high through a binary op: exactly one accept.
    add(OP_PUSH, 8'h10, 1'b0, 8'h10, 3'd2);
    issue(vecs[vecs.size()-1]);
    wait_ready(got);
    if (got) begin
      acc0 = accepts;
      hv.op = OP_ADD; hv.data = 8'h00; hv.is_err = 1'b0; hv.res = 8'hB5; hv.dep = 3'd1;
      sb.push_back(mk(hv, cyc));
      cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_data = 8'h00;
      for (int n = 0; n < 12; n++) begin
        @(negedge clk); #1;
        if (sb.size() == 0) break;
      end
      cmd_valid = 1'b0;
      check("single_accept", 32'(accepts - acc0), 32'd1);
      drain();
    end

    // Reset asserted in POP2 of an ADD aborts it silently.
    add(OP_PUSH, 8'h20, 1'b0, 8'h20, 3'd2);
    issue(vecs[vecs.size()-1]);
    wait_ready(got);
    if (got) begin
      k = cyc;
      cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_data = 8'h00;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pop2_cycle", 32'(cyc), 32'(k + 2));
      check("pop2_stk_pop", 32'(stk_pop), 32'd1);
      check("pop2_depth", 32'(depth), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_outputs",
            32'({cmd_ready, stk_push, stk_pop, res_valid, err, depth, res_data, stk_wdata}), 32'd0);
      repeat (3) @(negedge clk);
      check("abort_held", 32'({res_valid, err, depth}), 32'd0);
      rst = 1'b0;
      #1;
      check("ready_after_abort", 32'(cmd_ready), 32'd1);
      add(OP_PUSH, 8'h42, 1'b0, 8'h42, 3'd1);
      issue(vecs[vecs.size()-1]);
      add(OP_POP, 8'h00, 1'b0, 8'h42, 3'd0);
      issue(vecs[vecs.size()-1]);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
